// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// buffers the returned instruction for decode and applies execute redirects.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        id_ready,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state,       w_state_nxt;
    logic [63:0] r_pc,          w_pc_nxt;
    logic [63:0] r_req_pc,      w_req_pc_nxt;
    logic        r_kill,        w_kill_nxt;
    logic        r_if_valid,    w_if_valid_nxt;
    logic [31:0] r_if_instr,    w_if_instr_nxt;
    logic [63:0] r_if_pc,       w_if_pc_nxt;
    logic [31:0] r_fetch_count, w_fetch_count_nxt;
    logic [63:0] w_redirect_pc;

    // Masking rather than slicing keeps every redirect_pc bit in use.
    assign w_redirect_pc = redirect_pc & ~64'd3;

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_req_pc_nxt      = r_req_pc;
        w_kill_nxt        = r_kill;
        w_if_valid_nxt    = r_if_valid;
        w_if_instr_nxt    = r_if_instr;
        w_if_pc_nxt       = r_if_pc;
        w_fetch_count_nxt = r_fetch_count;

        case (r_state)
            S_IDLE: w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (imem_gnt) begin
                    w_req_pc_nxt = r_pc;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_if_instr_nxt = imem_rdata;
                        w_if_pc_nxt    = r_req_pc;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = r_req_pc + 64'd4;
                        w_state_nxt    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    w_if_valid_nxt    = 1'b0;
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                    w_state_nxt       = S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A redirect overrides the normal transition; any in-flight request becomes stale.
        if (redirect_valid) begin
            w_pc_nxt          = w_redirect_pc;
            w_if_valid_nxt    = 1'b0;
            w_if_instr_nxt    = r_if_instr;
            w_if_pc_nxt       = r_if_pc;
            w_fetch_count_nxt = r_fetch_count;
            case (r_state)
                S_ISSUE: begin
                    w_kill_nxt  = imem_gnt;
                    w_state_nxt = imem_gnt ? S_WAIT : S_ISSUE;
                end
                S_WAIT: begin
                    w_kill_nxt  = ~imem_rvalid;
                    w_state_nxt = imem_rvalid ? S_ISSUE : S_WAIT;
                end
                S_HOLD:  w_state_nxt = S_ISSUE;
                default: w_state_nxt = S_ISSUE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_kill        <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= 32'd0;
            r_if_pc       <= 64'd0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_req_pc      <= w_req_pc_nxt;
            r_kill        <= w_kill_nxt;
            r_if_valid    <= w_if_valid_nxt;
            r_if_instr    <= w_if_instr_nxt;
            r_if_pc       <= w_if_pc_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign imem_req    = (r_state == S_ISSUE);
    assign imem_addr   = r_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, all checked
// against an expected-PC-stream model and a behavioural instruction memory.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic [31:0] fetch_count;

    int          checks = 0;
    int          errors = 0;

    // Reference model: the next address whose instruction decode should see.
    logic [63:0] model_pc;
    int unsigned exp_count;
    logic [63:0] grants[$];

    // Behavioural memory: one outstanding request, configurable response latency.
    bit          mem_busy;
    int          mem_lat;
    logic [63:0] mem_addr;
    int          lat_lo;
    int          lat_hi;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    task automatic do_reset();
        reset          = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        id_ready       = 1'b0;
        model_pc       = 64'd0;
        exp_count      = 0;
        mem_busy       = 1'b0;
        mem_lat        = 0;
        mem_addr       = 64'd0;
        lat_lo         = 0;
        lat_hi         = 0;
        grants.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: drive inputs at the negedge, update the model, check after the edge.
    task automatic tick(input logic gnt, input logic rdy, input logic redir, input logic [63:0] rpc);
        logic granted;
        logic delivered;
        if (mem_busy && mem_lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
            mem_busy    = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mem_busy) mem_lat--;
        end
        imem_gnt       = gnt;
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        granted   = imem_req && gnt;
        delivered = if_valid && rdy && !redir;
        if (granted) begin
            grants.push_back(imem_addr);
            checks++;
            if (imem_addr !== model_pc) begin
                errors++;
                $display("FAIL grant_addr: got %h expected %h", imem_addr, model_pc);
            end
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_lat  = $urandom_range(lat_hi, lat_lo);
        end
        if (delivered) begin
            checks++;
            if (if_pc !== model_pc || if_instr !== mem_word(model_pc)) begin
                errors++;
                $display("FAIL deliver: got pc %h instr %h expected pc %h instr %h",
                         if_pc, if_instr, model_pc, mem_word(model_pc));
            end
            model_pc  = model_pc + 64'd4;
            exp_count = exp_count + 1;
        end
        if (redir) model_pc = rpc & ~64'd3;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (fetch_count !== exp_count) begin
            errors++;
            $display("FAIL fetch_count: got %0d expected %0d", fetch_count, exp_count);
        end
        if (redir) begin
            checks++;
            if (if_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_clears_valid: got %b expected 0", if_valid);
            end
        end
    endtask

    task automatic run_until(input int unsigned n, output int ticks);
        ticks = 0;
        while (exp_count < n && ticks < 100) begin
            tick(1'b1, 1'b1, 1'b0, 64'd0);
            ticks++;
        end
        checks++;
        if (exp_count < n) begin
            errors++;
            $display("FAIL run_until_timeout: got %0d deliveries expected %0d", exp_count, n);
        end
    endtask

    task automatic wait_hold();
        int k = 0;
        while (if_valid !== 1'b1 && k < 20) begin
            tick(1'b1, 1'b0, 1'b0, 64'd0);
            k++;
        end
        checks++;
        if (if_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_hold_timeout: got if_valid %b expected 1", if_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_count} !== 194'd0) begin
            errors++;
            $display("FAIL reset_values: got req %b addr %h v %b instr %h pc %h cnt %0d expected all 0",
                     imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_count);
        end
        do_reset();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got %b expected 0", imem_req);
        end
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin
            errors++;
            $display("FAIL first_issue: got req %b addr %h expected 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        int t;
        do_reset();
        run_until(3, t);
        checks++;
        if (t != 10) begin
            errors++;
            $display("FAIL zero_wait_cycles: got %0d expected 10", t);
        end
        checks++;
        if (grants.size() < 3 || grants[0] !== 64'd0 || grants[1] !== 64'd4 || grants[2] !== 64'd8) begin
            errors++;
            $display("FAIL addr_sequence: got %0d grants expected 0,4,8", grants.size());
        end
        checks++;
        if (fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL count_three: got %0d expected 3", fetch_count);
        end
    endtask

    task automatic test_stall();
        int t;
        do_reset();
        run_until(2, t);
        wait_hold();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0, 64'd0);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 64'd8 || if_instr !== mem_word(64'd8) || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got v %b pc %h instr %h req %b expected 1 8 %h 0",
                         if_valid, if_pc, if_instr, imem_req, mem_word(64'd8));
            end
        end
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd12) begin
            errors++;
            $display("FAIL stall_release: got req %b addr %h expected 1 c", imem_req, imem_addr);
        end
    endtask

    task automatic test_delayed_grant();
        int t;
        do_reset();
        run_until(1, t);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'd4) begin
                errors++;
                $display("FAIL delayed_grant_stable: got req %b addr %h expected 1 4", imem_req, imem_addr);
            end
            if (i < 3) tick(1'b0, 1'b1, 1'b0, 64'd0);
        end
        run_until(2, t);
    endtask

    task automatic test_redirect_wait();
        int t;
        int k;
        do_reset();
        run_until(2, t);
        lat_lo = 2;
        lat_hi = 2;
        tick(1'b1, 1'b1, 1'b0, 64'd0);
        lat_lo = 0;
        lat_hi = 0;
        tick(1'b0, 1'b1, 1'b1, 64'h100);
        k = 0;
        while (imem_req !== 1'b1 && k < 10) begin
            tick(1'b0, 1'b1, 1'b0, 64'd0);
            checks++;
            if (if_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_dropped: got if_valid %b pc %h expected 0", if_valid, if_pc);
            end
            k++;
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin
            errors++;
            $display("FAIL redirect_wait_addr: got req %b addr %h expected 1 100", imem_req, imem_addr);
        end
        run_until(3, t);
    endtask

    task automatic test_redirect_hold();
        int t;
        do_reset();
        run_until(1, t);
        wait_hold();
        tick(1'b0, 1'b1, 1'b1, 64'h203);
        checks++;
        if (fetch_count !== 32'd1 || imem_req !== 1'b1 || imem_addr !== 64'h200) begin
            errors++;
            $display("FAIL redirect_hold: got cnt %0d req %b addr %h expected 1 1 200",
                     fetch_count, imem_req, imem_addr);
        end
        run_until(2, t);
    endtask

    task automatic test_pc_wrap();
        int t;
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        tick(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_until(1, t);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin
            errors++;
            $display("FAIL pc_wrap: got req %b addr %h expected 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        int t;
        do_reset();
        run_until(1, t);
        lat_lo = 1;
        lat_hi = 1;
        tick(1'b1, 1'b1, 1'b0, 64'd0);
        reset = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_count} !== 194'd0) begin
            errors++;
            $display("FAIL async_reset_values: got req %b addr %h v %b instr %h pc %h cnt %0d expected all 0",
                     imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_count);
        end
        @(negedge clk);
        reset     = 1'b0;
        model_pc  = 64'd0;
        exp_count = 0;
        lat_lo    = 0;
        lat_hi    = 0;
        for (int i = 0; i < 2; i++) begin
            mem_busy = 1'b1;
            mem_lat  = 0;
            mem_addr = 64'd4;
            tick(1'b0, 1'b1, 1'b0, 64'd0);
            checks++;
            if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'd0) begin
                errors++;
                $display("FAIL late_rvalid_ignored: got v %b req %b addr %h expected 0 1 0",
                         if_valid, imem_req, imem_addr);
            end
        end
        run_until(1, t);
    endtask

    task automatic test_random();
        logic        redir;
        logic [63:0] rpc;
        do_reset();
        lat_lo = 0;
        lat_hi = 3;
        for (int i = 0; i < 1500; i++) begin
            redir = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) rpc = {32'hFFFF_FFFF, 24'hFF_FFFF, 8'($urandom)};
            else rpc = {32'd0, 32'($urandom)};
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, redir, rpc);
        end
        checks++;
        if (exp_count < 50) begin
            errors++;
            $display("FAIL random_progress: got %0d deliveries expected at least 50", exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_delayed_grant();
        test_redirect_wait();
        test_redirect_hold();
        test_pc_wrap();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the instruction-fetch stage. It owns the 64-bit program counter and issues one instruction-memory request at a time through a req/gnt/rvalid handshake. It buffers each returned instruction for decode behind a valid/ready handshake and applies branch redirects from execute, discarding stale responses. It sits between the instruction memory and the IF/ID boundary, replacing the free-running PC register.

## Interface
- RESET_PC, 64'd0, PC loaded on reset; the first fetch address.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  64  fetch address, always 4-byte aligned.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid (exactly one per granted request).
- imem_rdata  in  32  returned instruction.
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  64  redirect target; bits [1:0] ignored and forced to 0.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  32  buffered instruction.
- if_pc  out  64  address of if_instr.
- id_ready  in  1  decode consumes if_instr this cycle; low means stall.
- fetch_count  out  32  count of instructions delivered (if_valid & id_ready), wraps at 2^32.

## Operation
- Registers:
  - pc: next address to fetch.
  - kill: drop the next response.
  - state: IDLE, ISSUE, WAIT or HOLD.
  - Output buffer: if_instr, if_pc, if_valid.
  - fetch_count.
- IDLE: reset state. Move to ISSUE on the first clock after reset deasserts. imem_req=0.
- ISSUE: imem_req=1, imem_addr=pc.
  - imem_gnt=1 → WAIT. The granted address is latched internally as req_pc.
  - imem_gnt=0 → stay in ISSUE. imem_addr remains stable until granted, unless a redirect occurs.
- WAIT: imem_req=0.
  - imem_rvalid=1 and kill=0 → capture if_instr=imem_rdata, if_pc=req_pc, if_valid=1; set pc=req_pc+4; go to HOLD.
  - imem_rvalid=1 and kill=1 → discard the data, clear kill, go to ISSUE.
- HOLD: if_valid=1.
  - id_ready=1 → if_valid=0, fetch_count+1, go to ISSUE.
  - id_ready=0 → outputs held unchanged.
- redirect_valid=1 always wins over the normal transition:
  - pc := {redirect_pc[63:2],2'b00}; if_valid := 0; no fetch_count increment.
  - In ISSUE with imem_gnt=0: stay in ISSUE. The next cycle requests the new pc.
  - In ISSUE with imem_gnt=1: the old request is in flight. Go to WAIT with kill=1.
  - In WAIT with no rvalid: stay in WAIT with kill=1.
  - In WAIT with rvalid: drop the data, go to ISSUE.
  - In HOLD: drop the buffered instruction, go to ISSUE.
  - In IDLE: load pc only.
- pc+4 wraps modulo 2^64 with no error.
- Only one request is outstanding at a time. imem_rvalid outside WAIT is ignored.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, kill=0.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0, fetch_count=0.
- imem_req and imem_addr are decoded from registered state only; there is no combinational path from inputs.
- Zero-wait-state memory (gnt in ISSUE, rvalid the next cycle): if_valid rises 2 cycles after the ISSUE cycle.
- Best-case throughput: one instruction per 3 cycles (ISSUE, WAIT, HOLD).
- Redirect takes effect the cycle after it is sampled. if_valid is low on that cycle.
- Reset asserted mid-transaction: everything returns to reset values immediately. Any response arriving after reset is ignored because state is not WAIT.

## Test plan
- Reset release, zero-wait memory returning memory[addr>>2]:
  - imem_addr sequence is 0, 4, 8.
  - if_pc/if_instr match each address.
  - fetch_count=3 after three id_ready handshakes.
- Stall: hold id_ready=0 for 5 cycles in HOLD at if_pc=8.
  - if_valid, if_instr and if_pc remain stable.
  - No imem_req is issued.
  - Releasing the stall gives the next request at addr 12.
- Delayed grant: imem_gnt low for 3 cycles at addr 4.
  - imem_req is held high and imem_addr=4 stays stable throughout.
- Redirect in WAIT: redirect_pc=0x100 while the request for addr 8 is outstanding.
  - The response for 8 is dropped; if_valid never rises for pc 8.
  - The next imem_addr is 0x100.
- Redirect in HOLD with redirect_pc=0x203:
  - if_valid drops the next cycle.
  - The next imem_addr is 0x200.
  - fetch_count is unchanged.
- Async reset asserted in WAIT, then a late imem_rvalid arrives:
  - All outputs are at reset values and the response is ignored.
  - Fetch restarts at RESET_PC.
